// File: rtl/aes_pkg.sv
// Shared constants, state encoding and key-index helper for the column-serial
// AES round sequencer.
package aes_pkg;

    localparam int unsigned AES_DATA_W = 32;  // datapath column width
    localparam int unsigned AES_CC_W   = 2;   // beat-within-round counter width
    localparam int unsigned AES_RW     = 5;   // round counter width
    localparam int unsigned AES_KI_W   = 4;   // round-key index width

    localparam int unsigned AES_NR_128 = 10;
    localparam int unsigned AES_NR_192 = 12;
    localparam int unsigned AES_NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } aes_state_e;

    // Round key used by round rnd (1-based): ascending for encrypt, descending for decrypt.
    function automatic logic [AES_KI_W-1:0] key_index(input logic mode,
                                                       input int unsigned nr,
                                                       input int unsigned rnd);
        int unsigned k;
        k = rnd - 1;
        if (mode) k = nr - k;
        return AES_KI_W'(k);
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block input handshake and output burst framing between the AES wrapper and
// the round sequencer.
//   in_valid/in_mode : wrapper -> sequencer (beat valid, 0=enc 1=dec)
//   in_ready         : sequencer -> wrapper (first beat can be accepted)
//   out_valid/out_last : sequencer -> wrapper (output burst framing)
interface aes_round_sequencer_if;

    logic in_valid;
    logic in_mode;
    logic in_ready;
    logic out_valid;
    logic out_last;

    modport master (
        output in_valid,
        output in_mode,
        input  in_ready,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_mode,
        output in_ready,
        output out_valid,
        output out_last
    );

endinterface

// File: rtl/aes_cycle_counter.sv
// Beat/round counter for the sequencer.
//   clr   : force round 0 / beat 0 (highest priority)
//   start : first beat accepted, next cycle is round 1 beat 1
//   en    : advance beat, round increments on the 3->0 wrap
//   count_cycle/round_num : registered counters
//   cc_nxt_c/round_nxt_c  : next-cycle values, used to register decoded strobes
//   wrap_c                : current beat is the last of the round
module aes_cycle_counter
    import aes_pkg::*;
#(
    parameter int unsigned RW = AES_RW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                start,
    input  logic                en,
    output logic [AES_CC_W-1:0] count_cycle,
    output logic [RW-1:0]       round_num,
    output logic [AES_CC_W-1:0] cc_nxt_c,
    output logic [RW-1:0]       round_nxt_c,
    output logic                wrap_c
);

    assign wrap_c = (count_cycle == '1);

    // Next-value selection
    always_comb begin
        cc_nxt_c    = count_cycle;
        round_nxt_c = round_num;
        if (clr) begin
            cc_nxt_c    = '0;
            round_nxt_c = '0;
        end else if (start) begin
            cc_nxt_c    = AES_CC_W'(1);
            round_nxt_c = RW'(1);
        end else if (en) begin
            cc_nxt_c = count_cycle + AES_CC_W'(1);
            if (wrap_c) round_nxt_c = round_num + RW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_cycle <= '0;
            round_num   <= '0;
        end else begin
            count_cycle <= cc_nxt_c;
            round_num   <= round_nxt_c;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the 32-bit column-serial AES datapath. Takes one block
// as four consecutive beats, steps the datapath through NR rounds, requests
// round keys and frames the 4-beat output burst.
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : in_valid/in_mode/in_ready handshake, out_valid/out_last framing
//   abort         : synchronous return to IDLE
//   count_cycle   : beat within round (0..3)
//   round_num     : 0 idle, 1 input, 2..NR+1 compute, NR+2 output
//   idle_round/input_round/final_round/done_round/busy : round decodes
//   mode_o        : mode latched with the first beat
//   key_req/key_idx : one-cycle round-key request and its index
//   err           : one-cycle pulse on input burst underrun
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR_128,
    parameter int unsigned RW = AES_RW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_sequencer_if.slave  bus,
    input  logic                  abort,
    output logic [AES_CC_W-1:0]   count_cycle,
    output logic [RW-1:0]         round_num,
    output logic                  idle_round,
    output logic                  input_round,
    output logic                  final_round,
    output logic                  done_round,
    output logic                  mode_o,
    output logic                  key_req,
    output logic [AES_KI_W-1:0]   key_idx,
    output logic                  busy,
    output logic                  err
);

    localparam logic [RW-1:0] R_LAST_KEY = RW'(NR);      // last round whose wrap requests a key
    localparam logic [RW-1:0] R_FINAL    = RW'(NR + 1);
    localparam logic [RW-1:0] R_DONE     = RW'(NR + 2);

    aes_state_e            state, state_nxt;
    logic                  cnt_clr, cnt_start, cnt_en;
    logic                  mode_nxt, key_req_nxt, err_nxt;
    logic [AES_KI_W-1:0]   key_idx_nxt;
    logic [AES_CC_W-1:0]   cc_nxt;
    logic [RW-1:0]         round_nxt;
    logic                  wrap;

    aes_cycle_counter #(.RW(RW)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (cnt_clr),
        .start       (cnt_start),
        .en          (cnt_en),
        .count_cycle (count_cycle),
        .round_num   (round_num),
        .cc_nxt_c    (cc_nxt),
        .round_nxt_c (round_nxt),
        .wrap_c      (wrap)
    );

    // Next state, counter control and next values of the registered pulses
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        cnt_start   = 1'b0;
        cnt_en      = 1'b0;
        mode_nxt    = mode_o;
        key_req_nxt = 1'b0;
        key_idx_nxt = key_idx;
        err_nxt     = 1'b0;

        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // accept cycle is beat 0 of round 1; its key is requested here
                        state_nxt   = ST_LOAD;
                        cnt_start   = 1'b1;
                        mode_nxt    = bus.in_mode;
                        key_req_nxt = 1'b1;
                        key_idx_nxt = key_index(bus.in_mode, NR, 1);
                    end
                end
                ST_LOAD: begin
                    if (!bus.in_valid) begin
                        state_nxt = ST_IDLE;
                        cnt_clr   = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (wrap) state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_en = 1'b1;
                    if (wrap && round_num == R_FINAL) state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (wrap) begin
                        state_nxt = ST_IDLE;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end
            endcase
        end

        // Key for rounds 2..NR+1 is requested as beat 0 of that round begins
        if (cnt_en && wrap && round_num <= R_LAST_KEY) begin
            key_req_nxt = 1'b1;
            key_idx_nxt = key_index(mode_o, NR, 32'(round_nxt));
        end
    end

    // State and registered outputs (strobes decoded from next counter values)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mode_o        <= 1'b0;
            key_req       <= 1'b0;
            key_idx       <= '0;
            err           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            idle_round    <= 1'b1;
            input_round   <= 1'b0;
            final_round   <= 1'b0;
            done_round    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            mode_o        <= mode_nxt;
            key_req       <= key_req_nxt;
            key_idx       <= key_idx_nxt;
            err           <= err_nxt;
            bus.in_ready  <= (state_nxt == ST_IDLE);
            bus.out_valid <= (round_nxt == R_DONE);
            bus.out_last  <= (round_nxt == R_DONE) && (cc_nxt == '1);
            idle_round    <= (round_nxt == '0);
            input_round   <= (round_nxt == RW'(1));
            final_round   <= (round_nxt == R_FINAL);
            done_round    <= (round_nxt == R_DONE);
            busy          <= (round_nxt != '0);
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer (NR=10). k counts cycles from the
// accept cycle of a block (k=0); outputs are sampled on the falling edge.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam int NR = 10;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic [1:0]  count_cycle;
    logic [4:0]  round_num;
    logic        idle_round, input_round, final_round, done_round;
    logic        mode_o, key_req, busy, err;
    logic [3:0]  key_idx;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_sequencer_if bus();

    aes_round_sequencer #(.NR(NR), .RW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .abort       (abort),
        .count_cycle (count_cycle),
        .round_num   (round_num),
        .idle_round  (idle_round),
        .input_round (input_round),
        .final_round (final_round),
        .done_round  (done_round),
        .mode_o      (mode_o),
        .key_req     (key_req),
        .key_idx     (key_idx),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {round, cc, in_ready, busy, idle, input, final, done, out_valid, out_last, key_req, err}
    function automatic logic [17:0] obs_vec();
        return {round_num, count_cycle, bus.in_ready, busy, idle_round, input_round,
                final_round, done_round, bus.out_valid, bus.out_last, key_req, err};
    endfunction

    function automatic logic [17:0] pack_exp(int r, int cc, bit ir, bit kr, bit e);
        return {5'(r), 2'(cc), ir, (r != 0), (r == 0), (r == 1), (r == NR + 1),
                (r == NR + 2), (r == NR + 2), (r == NR + 2 && cc == 3), kr, e};
    endfunction

    // Expected outputs k cycles after the accept cycle of an uninterrupted block
    function automatic logic [17:0] exp_norm(int k);
        int r;
        int cc;
        bit kr;
        if (k == 0) return pack_exp(0, 0, 1'b1, 1'b0, 1'b0);
        r  = k / 4 + 1;
        cc = k % 4;
        kr = (k == 1) || (cc == 0 && r <= NR + 1);
        return pack_exp(r, cc, 1'b0, kr, 1'b0);
    endfunction

    function automatic int exp_kidx(int k, bit mode);
        int r;
        r = (k == 1) ? 1 : k / 4 + 1;
        return mode ? NR - (r - 1) : r - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_k(int k, bit mode);
        logic [17:0] e;
        e = exp_norm(k);
        check_eq($sformatf("blk k=%0d", k), 32'(obs_vec()), 32'(e));
        if (k >= 1) check_eq($sformatf("mode k=%0d", k), 32'(mode_o), 32'(mode));
        if (e[1]) check_eq($sformatf("kidx k=%0d", k), 32'(key_idx), 32'(exp_kidx(k, mode)));
    endtask

    // Full block; hold keeps in_valid high for all 48 cycles
    task automatic run_block(bit mode, bit hold);
        for (int k = 0; k < 48; k++) begin
            bus.in_valid = hold || (k < 4);
            bus.in_mode  = mode;
            @(negedge clk);
            check_k(k, mode);
            tick();
        end
    endtask

    task automatic idle_cycles(int n, bit err_first);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            check_eq($sformatf("idle i=%0d", i), 32'(obs_vec()),
                     32'(pack_exp(0, 0, 1'b1, 1'b0, err_first && i == 0)));
            tick();
        end
    endtask

    task automatic check_reset_vals(string tag);
        check_eq(tag, 32'({round_num, count_cycle, busy, input_round, final_round, done_round,
                           bus.out_valid, bus.out_last, key_req, err, mode_o, key_idx}), 32'(0));
    endtask

    initial begin
        rst_n        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        tick();
        idle_cycles(2, 1'b0);

        // encrypt, then decrypt
        run_block(1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        run_block(1'b1, 1'b0);
        idle_cycles(1, 1'b0);

        // underrun on beat 2
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = (k < 2);
            bus.in_mode  = 1'b0;
            @(negedge clk);
            check_k(k, 1'b0);
            tick();
        end
        idle_cycles(50, 1'b1);
        run_block(1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // abort during round 6
        for (int k = 0; k < 23; k++) begin
            bus.in_valid = (k < 4);
            bus.in_mode  = 1'b0;
            abort        = (k == 22);
            @(negedge clk);
            check_k(k, 1'b0);
            tick();
        end
        abort = 1'b0;
        idle_cycles(30, 1'b0);
        run_block(1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // abort and in_valid together in IDLE: beat not accepted
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq("abort_idle", 32'(obs_vec()), 32'(pack_exp(0, 0, 1'b1, 1'b0, 1'b0)));
        tick();
        abort = 1'b0;
        idle_cycles(2, 1'b0);

        // async reset during DONE beat 1 of a decrypt block
        for (int k = 0; k < 45; k++) begin
            bus.in_valid = (k < 4);
            bus.in_mode  = 1'b1;
            @(negedge clk);
            check_k(k, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        idle_cycles(2, 1'b0);

        // back-to-back blocks, in_valid held high
        run_block(1'b0, 1'b1);
        run_block(1'b1, 1'b1);
        idle_cycles(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Control sequencer for the 32-bit column-serial AES-128 datapath (ShiftRows shift register, S-box, MixColumns, AddRoundKey stages). It accepts one 128-bit block as four 32-bit beats and generates the per-cycle and per-round control strobes: count_cycle, round number, idle, input, final and done. It also issues round-key requests to the key schedule and frames the 4-beat output burst. It sits between the bus-side AES wrapper and the datapath, and is the only source of datapath timing.

Parameters:
NR, 10, number of AES rounds (10 for AES-128; 12/14 legal, round_num must fit 5 bits)
RW, 5, round counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  sequencer can accept first beat of a block
in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with first beat
abort  in  1  synchronous abort; return to IDLE
count_cycle  out  2  beat index within current round (0..3)
round_num  out  RW  0 = idle, 1 = input round, 2..NR+1 = compute rounds, NR+2 = done round
idle_round  out  1  round_num == 0
input_round  out  1  round_num == 1
final_round  out  1  round_num == NR+1 (datapath skips MixColumns)
done_round  out  1  round_num == NR+2
mode_o  out  1  latched mode for the current block
key_req  out  1  one-cycle pulse requesting round key key_idx
key_idx  out  4  round-key index
out_valid  out  1  output beat valid (equals done_round)
out_last  out  1  final output beat (done_round && count_cycle==3)
busy  out  1  round_num != 0
err  out  1  one-cycle pulse on input burst underrun

Behaviour:
- Reset on rst_n: round_num=0, count_cycle=0, mode_o=0; all strobes/pulses 0; in_ready=1 after reset.
- States: IDLE (round 0), LOAD (round 1), RUN (rounds 2..NR+1), DONE (round NR+2).
- IDLE: in_ready=1, count_cycle held at 0. in_valid=1 -> accept beat 0, latch mode_o=in_mode, next cycle round_num=1, count_cycle=1. The accepted cycle is counted as beat 0 of round 1 (round_num updates registered, so the datapath sees input_round from beat 1; the datapath treats idle→load as shift-in).
- LOAD: in_ready=0. Beats 1..3 require in_valid=1 on consecutive cycles. If in_valid=0 during LOAD: err pulse next cycle, return to IDLE (round_num=0, count_cycle=0). No backpressure or stall anywhere once a block is started.
- count_cycle increments every cycle while busy and wraps 3→0. round_num increments on the wrap.
- RUN: rounds 2..NR+1. final_round is asserted for all 4 cycles of round NR+1.
- DONE: round NR+2. out_valid=1 for 4 cycles; out_last on count_cycle==3. After the wrap: round_num=0, in_ready=1. There is exactly one IDLE cycle between blocks.
- Latency: first input beat at cycle T -> first out_valid at T+4*(NR+1) (44 for NR=10). Output burst occupies T+44..T+47.
- Key requests: key_req pulses at count_cycle==0 of rounds 1..NR+1, with key_idx = round_num-1 (encrypt) or NR-(round_num-1) (decrypt). The round-1 request fires on the accept cycle with key_idx 0 (enc) or NR (dec).
- abort (any state): next cycle IDLE, all strobes 0, no err, no out_valid. If abort and in_valid arrive in IDLE on the same cycle, abort wins and the beat is not accepted.
- Mid-operation reset: same as power-on reset. Strobes are never left partially asserted.
- All outputs are registered or decoded from registered round_num/count_cycle. There are no combinational paths from in_valid to outputs except in_ready (which depends only on state).

Decomposition:
- Shared package aes_pkg: AES_DATA_W=32, AES_CC_W=2, AES_RW=5, NR constants per key size, state encoding typedef (IDLE/LOAD/RUN/DONE).
- One natural sub-module: aes_cycle_counter (count_cycle + round_num counter with clear/enable and wrap). The FSM, key-index logic and handshake stay in the top.

Test Plan:
- Encrypt block, in_valid held 4 cycles from T=10 -> input_round cycles 11..13, final_round during round 11, out_valid cycles 54..57, out_last at 57, in_ready at 58.
- Decrypt block -> key_idx sequence 10,9,...,0 on key_req pulses every 4 cycles; mode_o=1 held throughout.
- in_valid drops on beat 2 -> err one pulse; returns to IDLE; in_ready=1; no out_valid; next block completes normally.
- abort asserted in round 6 -> next cycle round_num=0, busy=0, no out_valid; subsequent block has normal latency 44.
- rst_n asserted during DONE beat 1 -> all outputs 0 immediately (async); in_ready=1 after release.
- Back-to-back blocks with in_valid constantly high -> blocks accepted 45... exact spacing 48 cycles (44 + 4), one IDLE cycle between bursts; all 8 output beats framed correctly.
